ring_seq_decoder: RTL

- Receive side of the team's one-hot ring counter: samples a WIDTH-bit ring vector and converts the hot bit to a binary index.
- Checks that each enabled sample is the previous sample rotated by one position toward the MSB, with wrap from the MSB back to bit 0.
- Declares lock after LOCK_CNT consecutive correct advances and pulses an error on any sequence break while locked.
- Sits downstream of ring_counter instances as a phase decoder and health monitor.

---
 rtl/ring_pkg.sv | 24 ++
 rtl/ring_onehot_enc.sv | 22 ++
 rtl/ring_seq_decoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for one-hot ring producers and consumers.
// Used by ring_seq_decoder (optional err_cnt: RING_SEQ_DECODER_ERRCNT_EN).
package ring_pkg;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } ring_state_t;

  localparam int ERRCNT_W = 8;
  localparam int ROT_MAX  = 64;

  // Bit k moves to k+1, bit w-1 wraps to 0; callers truncate to w bits.
  function automatic logic [ROT_MAX-1:0] rotl(
    input logic [ROT_MAX-1:0] v,
    input int                 w
  );
    logic [ROT_MAX-1:0] r;
    r = (v << 1) | ROT_MAX'(v[w-1]);
    return r;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot to binary encoder with a one-hot validity flag.
// Reusable by any ring consumer.
module ring_onehot_enc #(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             onehot
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign onehot = (vec != '0) &&
                  ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_seq_decoder.sv
// Ring phase decoder and sequence health monitor.
// Optional err_cnt output: define RING_SEQ_DECODER_ERRCNT_EN.
module ring_seq_decoder
  import ring_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 3,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             idx_vld,
  output logic             locked,
  output logic             err
`ifdef RING_SEQ_DECODER_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  ring_state_t      state;
  ring_state_t      state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0] prev;
  logic [IDX_W-1:0] enc_idx;
  logic             oh;
  logic             match;
  logic             err_n;
  logic [IDX_W-1:0] idx_n;
  logic             vld_n;
  logic             locked_n;

  ring_onehot_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .vec    (ring_in),
    .idx    (enc_idx),
    .onehot (oh)
  );

  assign match = (ring_in ==
                  WIDTH'(rotl(ROT_MAX'(prev), WIDTH)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= UNLOCK;
      cnt     <= '0;
      prev    <= '0;
      idx     <= '0;
      idx_vld <= 1'b0;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      idx_vld <= vld_n;
      locked  <= locked_n;
      err     <= err_n;
      if (en) prev <= ring_in;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = 1'b0;
    if (en) begin
      unique case (state)
        UNLOCK: begin
          if (oh) begin
            state_n = TRACK;
            cnt_n   = '0;
          end
        end
        TRACK: begin
          if (!oh) begin
            state_n = UNLOCK;
            cnt_n   = '0;
          end else if (match) begin
            cnt_n = cnt + 1'b1;
            if (cnt_n == CNT_W'(LOCK_CNT)) state_n = LOCKED;
          end else begin
            cnt_n = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = oh ? TRACK : UNLOCK;
          end
        end
        default: begin
          state_n = UNLOCK;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    idx_n    = idx;
    vld_n    = idx_vld;
    locked_n = (state_n == LOCKED);
    if (en) begin
      vld_n = oh;
      if (oh) idx_n = enc_idx;
    end
  end

`ifdef RING_SEQ_DECODER_ERRCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_n && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
